// File: rtl/rv_pkg.sv
// ---------------------------------------------------------------------------
// rv_pkg
// Shared definitions for the integer register file and its scoreboard.
// Contents:
//   DEF_XLEN   - default register data width
//   DEF_AW     - default register address width
//   REG_ZERO   - index of the hard-wired zero register
//   reg_addr_t - register address type at the default address width
// ---------------------------------------------------------------------------
package rv_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_AW   = 5;
    localparam int REG_ZERO = 0;

    typedef logic [DEF_AW-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard_if
// Bundles the decode-side read/hazard ports, the issue port and the
// writeback port of the register file.
// Modports:
//   master - pipeline side: drives addresses, issue, writeback and flush;
//            observes read data, busy flags and the pending count
//   slave  - register file side: the mirror image of master
// Signals:
//   A1/A2, RD1/RD2, busy1/busy2 - read ports with hazard flags
//   A3, WE3, WD3                - writeback port
//   IE, IA                      - issue port (marks IA pending)
//   flush                       - clears all pending bits
//   pend_cnt                    - number of pending registers
// ---------------------------------------------------------------------------
interface regfile_scoreboard_if
    import rv_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int AW   = DEF_AW
);

    logic [AW-1:0]   A1;
    logic [AW-1:0]   A2;
    logic [XLEN-1:0] RD1;
    logic [XLEN-1:0] RD2;
    logic            busy1;
    logic            busy2;
    logic [AW-1:0]   A3;
    logic            WE3;
    logic [XLEN-1:0] WD3;
    logic            IE;
    logic [AW-1:0]   IA;
    logic            flush;
    logic [AW:0]     pend_cnt;

    modport master (
        output A1, A2, A3, WE3, WD3, IE, IA, flush,
        input  RD1, RD2, busy1, busy2, pend_cnt
    );

    modport slave (
        input  A1, A2, A3, WE3, WD3, IE, IA, flush,
        output RD1, RD2, busy1, busy2, pend_cnt
    );

endinterface

// File: rtl/scoreboard_bits.sv
// ---------------------------------------------------------------------------
// scoreboard_bits
// Owns one pending bit per register, the flush/issue/writeback priority that
// updates them, the registered pending count and the raw busy lookup for the
// two read addresses.
// Ports:
//   clk, rst          - clock, asynchronous active-low reset
//   ie, ia            - issue enable / destination register
//   we, wa            - writeback enable / destination register
//   flush             - clears every pending bit
//   ra1, ra2          - read addresses for the busy lookup
//   busy1, busy2      - pending bit of ra1 / ra2 (no bypass applied)
//   pend_cnt          - population count of the pending vector
// ---------------------------------------------------------------------------
module scoreboard_bits
    import rv_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ie,
    input  logic [AW-1:0] ia,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic          flush,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic          busy1,
    output logic          busy2,
    output logic [AW:0]   pend_cnt
);

    localparam int NREGS = 2**AW;
    localparam int CW    = AW + 1;
    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_next;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_next;
    logic             issue_ok;

    // An issue to the zero register never creates a hazard, so it is dropped
    // here instead of being set and then masked.
    assign issue_ok = ie && !((ZERO_REG != 0) && (ia == ZERO_ADDR));

    // Next pending vector and count. Flush wins outright. Otherwise the
    // writeback clear is suppressed when a new producer issues to the same
    // register on the same edge, so the newer instruction keeps the hazard.
    // The count is tracked incrementally by looking at the old value of each
    // bit touched, which keeps it equal to the popcount without an adder tree.
    always_comb begin
        pend_next = pend;
        cnt_next  = cnt;
        if (flush) begin
            pend_next = '0;
            cnt_next  = '0;
        end else begin
            if (we && !(issue_ok && (ia == wa))) begin
                pend_next[wa] = 1'b0;
                if (pend[wa]) begin
                    cnt_next = cnt_next - CW'(1);
                end
            end
            if (issue_ok) begin
                pend_next[ia] = 1'b1;
                if (!pend[ia]) begin
                    cnt_next = cnt_next + CW'(1);
                end
            end
        end
        if (ZERO_REG != 0) begin
            pend_next[ZERO_ADDR] = 1'b0;
        end
    end

    // Pending state and count registers; reset drops every outstanding write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
            cnt  <= '0;
        end else begin
            pend <= pend_next;
            cnt  <= cnt_next;
        end
    end

    assign busy1    = pend[ra1];
    assign busy2    = pend[ra2];
    assign pend_cnt = cnt;

endmodule

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Integer register file with two combinational read ports, one synchronous
// writeback port and a per-register pending scoreboard for hazard detection.
// Parameters:
//   XLEN     - register width
//   AW       - address width (2**AW registers)
//   ZERO_REG - 1: register 0 reads 0, ignores writes, is never pending
//   BYPASS   - 1: same-cycle writeback data is forwarded to the read ports
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - asynchronous active-low reset
//   bus  - regfile_scoreboard_if slave modport (read, issue, writeback, flush)
// ---------------------------------------------------------------------------
module regfile_scoreboard
    import rv_pkg::*;
#(
    parameter int XLEN     = DEF_XLEN,
    parameter int AW       = DEF_AW,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_scoreboard_if.slave  bus
);

    localparam int NREGS = 2**AW;
    localparam logic [AW-1:0] ZERO_ADDR = AW'(REG_ZERO);

    logic [XLEN-1:0] regs [NREGS];
    logic            wr_ok;
    logic            fwd1;
    logic            fwd2;
    logic            sb_busy1;
    logic            sb_busy2;

    // A write to the zero register is dropped; that same qualified enable
    // decides forwarding, so a read of register 0 is never forwarded.
    always_comb begin
        wr_ok = bus.WE3 && !((ZERO_REG != 0) && (bus.A3 == ZERO_ADDR));
        fwd1  = (BYPASS != 0) && wr_ok && (bus.A3 == bus.A1);
        fwd2  = (BYPASS != 0) && wr_ok && (bus.A3 == bus.A2);
    end

    // Register storage: cleared asynchronously, written on the rising edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_ok) begin
            regs[bus.A3] <= bus.WD3;
        end
    end

    // Read muxes: stored value, overridden by forwarded writeback data, and
    // finally forced to zero for the hard-wired zero register.
    always_comb begin
        bus.RD1 = regs[bus.A1];
        if (fwd1) begin
            bus.RD1 = bus.WD3;
        end
        if ((ZERO_REG != 0) && (bus.A1 == ZERO_ADDR)) begin
            bus.RD1 = '0;
        end
        bus.RD2 = regs[bus.A2];
        if (fwd2) begin
            bus.RD2 = bus.WD3;
        end
        if ((ZERO_REG != 0) && (bus.A2 == ZERO_ADDR)) begin
            bus.RD2 = '0;
        end
    end

    // A register being forwarded this cycle is no longer a hazard, so its
    // busy flag is hidden even though its pending bit clears only at the edge.
    always_comb begin
        bus.busy1 = sb_busy1 && !fwd1;
        bus.busy2 = sb_busy2 && !fwd2;
    end

    scoreboard_bits #(
        .AW       (AW),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .ie       (bus.IE),
        .ia       (bus.IA),
        .we       (bus.WE3),
        .wa       (bus.A3),
        .flush    (bus.flush),
        .ra1      (bus.A1),
        .ra2      (bus.A2),
        .busy1    (sb_busy1),
        .busy2    (sb_busy2),
        .pend_cnt (bus.pend_cnt)
    );

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-issue integer register file: 2 combinational read ports, 1 synchronous write port.
- Adds a per-register pending (scoreboard) bit set at instruction issue and cleared at writeback, plus a pipeline flush.
- Adds optional write-to-read bypass, a hard-wired zero register and an outstanding-write counter.
- Sits between decode (reads, hazard check, issue) and writeback of the pipelined RISC-V core.

Parameters:
- XLEN, 32, data width of each register.
- AW, 5, address width; register count NREGS = 2**AW (derived localparam, not overridable).
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and is never pending; 0 = register 0 is ordinary.
- BYPASS, 1, 1 = same-cycle writeback data is forwarded to the read ports; 0 = reads return stored contents only.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous active-low reset.
- A1, input, AW, read port 1 address.
- A2, input, AW, read port 2 address.
- RD1, output, XLEN, read port 1 data (combinational).
- RD2, output, XLEN, read port 2 data (combinational).
- busy1, output, 1, register A1 has an outstanding write (combinational).
- busy2, output, 1, register A2 has an outstanding write (combinational).
- A3, input, AW, writeback address.
- WE3, input, 1, writeback enable.
- WD3, input, XLEN, writeback data.
- IE, input, 1, issue enable; marks IA as pending.
- IA, input, AW, issue destination address.
- flush, input, 1, clears all pending bits.
- pend_cnt, output, AW+1, number of registers currently pending (registered).

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-low; it is checked before any clock activity.
- Reset (rst=0), applied immediately and independent of clk:
  - all registers = 0; all pending bits = 0; pend_cnt = 0.
  - RD1/RD2 = 0 and busy1/busy2 = 0 while in reset (follows from cleared state).
  - Reset mid-operation discards all outstanding writes and pending state.
- Write: on the rising edge with WE3=1, registers[A3] <= WD3.
  - With ZERO_REG=1 and A3=0, the write is dropped.
- Read, combinational, zero latency:
  - RDn = registers[An].
  - If BYPASS=1 and WE3=1 and A3==An (and An != 0 when ZERO_REG=1), then RDn = WD3.
  - With ZERO_REG=1 and An=0, RDn = 0 always.
- Pending bit p[r], updated on the rising edge, in priority order:
  1. flush=1: all p <= 0. A concurrent IE is ignored (the issuing instruction is flushed). A concurrent WE3 still writes data.
  2. Otherwise, IE=1 and WE3=1 with IA==A3: p[IA] <= 1. The new producer wins.
  3. Otherwise, IE=1 sets p[IA] <= 1 and WE3=1 clears p[A3] <= 0, independently.
  - With ZERO_REG=1, p[0] is held at 0 and an issue to address 0 is ignored.
  - A writeback to a non-pending register is legal: data is written and p stays 0.
  - A re-issue to an already-pending register keeps p=1; no nesting or count is kept per register.
- busyn:
  - busyn = p[An], except it is forced to 0 when BYPASS=1 and a WE3 to An occurs the same cycle (the data is forwarded).
  - With BYPASS=0, busyn = p[An] unmodified.
- pend_cnt:
  - Registered, equals the population count of p after each edge.
  - Updated incrementally: +1 if a newly set bit was 0, -1 if a cleared bit was 1, both applied in the same cycle.
  - Set to 0 on flush.
  - Must never exceed NREGS-ZERO_REG and never underflow.
- No X propagation: all addresses are full-range, so no out-of-range case exists.

Decomposition:
- Shared package rv_pkg:
  - XLEN and AW defaults.
  - REG_ZERO = 0 localparam.
  - Register-address typedef.
- Sub-module scoreboard_bits:
  - Owns the pending vector, flush/issue/writeback priority, pend_cnt and busy lookup.
  - Parametrised on AW and ZERO_REG.
- Data array, bypass and zero muxing stay in the top module.

Test Plan:
- Reset then read: rst low, then high; A1=5, A2=31 -> RD1=RD2=0, busy=0, pend_cnt=0. Asserting rst mid-stream after writes -> all reads 0 immediately, without waiting for a clock edge.
- Write/read back: WE3=1, A3=7, WD3=32'hDEADBEEF; next cycle A1=7 -> RD1=32'hDEADBEEF. Write to A3=0 with data 32'h1234 -> RD at address 0 = 0 (ZERO_REG=1).
- Bypass:
  - BYPASS=1, p[9]=1 from a prior issue; WE3=1, A3=9, WD3=32'hA5A5A5A5 with A1=9 in the same cycle -> RD1=32'hA5A5A5A5, busy1=0.
  - Next cycle p[9]=0 and pend_cnt decrements.
  - Repeat with BYPASS=0 -> same cycle RD1 = old value, busy1=1.
- Issue/writeback collision: p[4]=1; IE=1, IA=4 and WE3=1, A3=4 on the same edge -> p[4] stays 1, pend_cnt unchanged, data written. IE=1, IA=6 with WE3=1, A3=4 -> p[6]=1, p[4]=0, pend_cnt unchanged.
- Flush: issue registers 1, 2, 3 (pend_cnt=3); flush=1 with IE=1, IA=8 and WE3=1, A3=2, WD3=32'h77 -> all busy=0, pend_cnt=0, p[8]=0, registers[2]=32'h77.
- Fill: issue registers 1..31 on consecutive cycles -> pend_cnt=31. A further issue to 0 -> no change. Write back all 31 -> pend_cnt=0, with no underflow on an extra writeback to a non-pending register.
